esi_msg_byte_serializer: RTL

//   Transmit-side counterpart to the cosim endpoint's byte-buffer-to-packed-message path.

---
 rtl/esi_msg_byte_serializer.sv | 109 ++++++++++
 1 files changed

// File: rtl/esi_msg_byte_serializer.sv
// Serializes one packed ESI message per handshake into an LSB-first byte stream with optional ID header.
// Latency: first byte 1 cycle after capture; backpressure holds the current byte, next message may capture on the last-byte transfer.
module esi_msg_byte_serializer #(
  parameter int          TYPE_SIZE_BITS = 32,
  parameter logic [7:0]  ENDPOINT_ID    = 8'h00,
  parameter bit          HEADER_EN      = 1'b1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      MsgInValid,
  output logic                      MsgInReady,
  input  logic [TYPE_SIZE_BITS-1:0] MsgIn,
  output logic                      ByteOutValid,
  input  logic                      ByteOutReady,
  output logic [7:0]                ByteOut,
  output logic                      ByteOutLast,
  output logic                      Busy
);

  localparam int TYPE_SIZE_BYTES = (TYPE_SIZE_BITS + 7) / 8;
  localparam int BUF_W           = TYPE_SIZE_BYTES * 8;
  localparam int IDX_W           = (TYPE_SIZE_BYTES > 1) ? $clog2(TYPE_SIZE_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TYPE_SIZE_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [BUF_W-1:0]   r_buf;
  logic               r_busy;
  logic               w_is_last;
  logic               w_xfer;
  logic               w_cap;
  logic [BUF_W-1:0]   w_msg_ext;

  assign w_msg_ext = BUF_W'(MsgIn);
  assign Busy      = r_busy;

  always_comb begin
    w_state_nxt  = r_state;
    w_is_last    = (r_state == S_DATA) && (r_idx == LAST_IDX);
    ByteOutValid = (r_state != S_IDLE);
    ByteOutLast  = w_is_last;
    ByteOut      = 8'h00;
    // The last-byte transfer cycle doubles as a capture slot so back-to-back messages leave no bubble.
    MsgInReady   = (r_state == S_IDLE) || (w_is_last && ByteOutReady);
    w_xfer       = ByteOutValid && ByteOutReady;
    w_cap        = MsgInValid && MsgInReady;

    case (r_state)
      S_HDR:   ByteOut = ENDPOINT_ID;
      S_DATA:  ByteOut = r_buf[7:0];
      default: ByteOut = 8'h00;
    endcase

    case (r_state)
      S_IDLE: begin
        if (w_cap) begin
          if (HEADER_EN) w_state_nxt = S_HDR;
          else           w_state_nxt = S_DATA;
        end
      end
      S_HDR: begin
        if (w_xfer) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_xfer && w_is_last) begin
          if (w_cap) begin
            if (HEADER_EN) w_state_nxt = S_HDR;
            else           w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Buffer shifts right on each data transfer so the current byte is always in the low lane.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx <= '0;
      r_buf <= '0;
    end else if (w_cap) begin
      r_idx <= '0;
      r_buf <= w_msg_ext;
    end else if ((r_state == S_DATA) && w_xfer && !w_is_last) begin
      r_idx <= r_idx + IDX_W'(1);
      r_buf <= r_buf >> 8;
    end
  end

endmodule
